// File: rtl/miic_reg_seq.sv
// IIC register-access sequencer: turns one host read/write command into a short
// series of byte operations for an IIC byte engine, with a per-op timeout and engine reset.
module miic_reg_seq #(
  parameter int TIMEOUT    = 2000000,
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       op_valid,
  output logic       op_start,
  output logic       op_stop,
  output logic       op_rnw,
  output logic [7:0] op_wr_data,
  input  logic [7:0] op_rd_data,
  input  logic       op_ack,
  input  logic       op_err,
  output logic       iic_rst
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESET, DONE} state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       rnw;
    logic [7:0] data;
  } op_t;

  // Byte-op table: writes are S+addr/W, reg, data+P; reads add a repeated start and a read+P.
  function automatic op_t op_fields(input logic rnw, input logic [6:0] addr,
                                    input logic [7:0] rg, input logic [7:0] wd,
                                    input logic [1:0] idx);
    op_t o;
    o = '0;
    case (idx)
      2'd0: begin o.start = 1'b1; o.data = {addr, 1'b0}; end
      2'd1: begin o.data = rg; end
      2'd2: begin
        if (rnw) begin o.start = 1'b1; o.data = {addr, 1'b1}; end
        else     begin o.stop  = 1'b1; o.data = wd; end
      end
      default: begin o.stop = 1'b1; o.rnw = 1'b1; o.data = 8'h00; end
    endcase
    return o;
  endfunction

  state_t              r_state;
  logic                r_rnw;
  logic [6:0]          r_addr;
  logic [7:0]          r_reg;
  logic [7:0]          r_wdata;
  logic [1:0]          r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [RCNT_W-1:0]   r_rcnt;
  logic                r_nack;
  op_t                 r_op;
  logic                r_op_valid;
  logic                r_rsp_valid;
  logic [7:0]          r_rsp_rdata;
  logic                r_rsp_nack;
  logic                r_rsp_timeout;
  logic                r_iic_rst;
  logic                r_busy;

  logic w_cmd_ready;
  logic w_accept;
  logic w_last;
  logic w_nack_next;

  assign w_cmd_ready = (r_state == IDLE) && !r_iic_rst;
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_last      = r_rnw ? (r_idx == 2'd3) : (r_idx == 2'd2);
  // NACK only means something on write-direction ops
  assign w_nack_next = r_nack | (op_err & ~r_op.rnw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rnw         <= 1'b0;
      r_addr        <= '0;
      r_reg         <= '0;
      r_wdata       <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_rcnt        <= '0;
      r_nack        <= 1'b0;
      r_op          <= '0;
      r_op_valid    <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_nack    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_iic_rst     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rnw      <= cmd_rnw;
            r_addr     <= cmd_addr;
            r_reg      <= cmd_reg;
            r_wdata    <= cmd_wdata;
            r_idx      <= 2'd0;
            r_nack     <= 1'b0;
            r_cnt      <= '0;
            r_op       <= op_fields(cmd_rnw, cmd_addr, cmd_reg, cmd_wdata, 2'd0);
            r_op_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // An ack on the cycle the counter expires still counts as a normal ack
          if (op_ack) begin
            r_op_valid <= 1'b0;
            r_nack     <= w_nack_next;
            if (w_last) begin
              r_state       <= DONE;
              r_rsp_valid   <= 1'b1;
              r_rsp_nack    <= w_nack_next;
              r_rsp_timeout <= 1'b0;
              r_rsp_rdata   <= r_rnw ? op_rd_data : 8'h00;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= GAP;
            end
          end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_op_valid <= 1'b0;
              r_iic_rst  <= 1'b1;
              r_rcnt     <= '0;
              r_state    <= RESET;
            end
          end else begin
            r_state <= WAIT;
          end
        end
        GAP: begin
          r_op       <= op_fields(r_rnw, r_addr, r_reg, r_wdata, r_idx);
          r_op_valid <= 1'b1;
          r_cnt      <= '0;
          r_state    <= ISSUE;
        end
        RESET: begin
          if (r_rcnt == RCNT_W'(RST_CYCLES - 1)) begin
            r_iic_rst     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_nack    <= r_nack;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= 8'h00;
            r_state       <= DONE;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign busy        = r_busy;
  assign op_valid    = r_op_valid;
  assign op_start    = r_op.start;
  assign op_stop     = r_op.stop;
  assign op_rnw      = r_op.rnw;
  assign op_wr_data  = r_op.data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_nack    = r_rsp_nack;
  assign rsp_timeout = r_rsp_timeout;
  assign iic_rst     = r_iic_rst;

endmodule

// File: tb/tb_miic_reg_seq.sv
// Bench for miic_reg_seq: scripted byte-engine model plus a transaction-level
// reference that predicts every issued op and every response.
module tb_miic_reg_seq;

  localparam int TO  = 100;
  localparam int RST = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_rnw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid, rsp_nack, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  logic       op_valid, op_start, op_stop, op_rnw;
  logic [7:0] op_wr_data, op_rd_data;
  logic       op_ack, op_err, iic_rst;

  miic_reg_seq #(.TIMEOUT(TO), .RST_CYCLES(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .op_valid(op_valid), .op_start(op_start), .op_stop(op_stop), .op_rnw(op_rnw),
    .op_wr_data(op_wr_data), .op_rd_data(op_rd_data), .op_ack(op_ack),
    .op_err(op_err), .iic_rst(iic_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // engine behaviour knobs, written by the stimulus process only
  int         eng_lat;
  int         eng_stall;
  logic [3:0] eng_err;
  logic [7:0] eng_rdata;
  int         spur_req;
  int         test_id;

  // written by the compare process only
  int checks;
  int failures;
  int rsp_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (test %0d, t=%0t)", nm, act, exp, test_id, $time);
    end
  endtask

  // Byte-engine model: acks each op eng_lat cycles after op_valid rises, never acks op eng_stall
  initial begin
    int e_cnt, e_opi, spur_done;
    bit e_acked;
    op_ack = 1'b0; op_err = 1'b0; op_rd_data = 8'h00;
    e_cnt = 0; e_opi = 0; e_acked = 0; spur_done = 0;
    forever begin
      @(posedge clk); #1;
      op_ack = 1'b0; op_err = 1'b0; op_rd_data = 8'h00;
      if (!rst_n || rsp_valid) begin
        e_opi = 0; e_cnt = 0; e_acked = 0;
      end else if (op_valid && !e_acked) begin
        e_cnt++;
        if (e_cnt == eng_lat && e_opi != eng_stall) begin
          op_ack     = 1'b1;
          op_err     = eng_err[e_opi];
          op_rd_data = (e_opi == 3) ? eng_rdata : 8'hEE;
          e_acked    = 1;
        end
      end else if (!op_valid) begin
        if (e_acked) e_opi++;
        e_acked = 0; e_cnt = 0;
      end
      if (spur_req != spur_done) begin
        spur_done  = spur_req;
        op_ack     = 1'b1;
        op_err     = 1'b1;
        op_rd_data = 8'hFF;
      end
    end
  end

  // Reference + compare process
  initial begin
    bit          in_txn, wd_fired;
    logic [10:0] exp_q[$];
    logic [10:0] cur_op, w_op;
    logic [10:0] log_op[4];
    logic [9:0]  last_rsp;
    logic [7:0]  exp_rd;
    logic        exp_nack, exp_to, prev_ov, prev_ir, prev_rv;
    int          age, n_iss, hi_run, low_run, ir_run, m_lat, m_stall, nops, idx;
    checks = 0; failures = 0; rsp_cnt = 0;
    in_txn = 0; wd_fired = 0; last_rsp = '0; cur_op = '0;
    exp_rd = '0; exp_nack = 0; exp_to = 0;
    prev_ov = 0; prev_ir = 0; prev_rv = 0;
    age = 0; n_iss = 0; hi_run = 0; low_run = 0; ir_run = 0; m_lat = 0; m_stall = -1;
    for (int i = 0; i < 4; i++) log_op[i] = '0;
    forever begin
      @(negedge clk);
      w_op = {op_start, op_stop, op_rnw, op_wr_data};
      if (!rst_n) begin
        chk("reset_outputs", 32'({busy, op_valid, w_op, rsp_valid, rsp_nack, rsp_timeout,
                                  rsp_rdata, iic_rst}), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        in_txn = 0; wd_fired = 0; exp_q.delete(); last_rsp = '0;
        prev_ov = 0; prev_ir = 0; prev_rv = 0; ir_run = 0; hi_run = 0; low_run = 0;
      end else begin
        chk("busy", 32'(busy), 32'(in_txn));
        chk("cmd_ready", 32'(cmd_ready), 32'(!in_txn));
        if (in_txn) begin
          age++;
          if (age > 1000 && !wd_fired) begin
            wd_fired = 1;
            checks++; failures++;
            $display("FAIL txn_watchdog no response after %0d cycles (test %0d)", age, test_id);
          end
        end
        if (op_valid) begin
          if (!prev_ov) begin
            chk("op_in_txn", 32'(in_txn), 32'd1);
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL op_extra got=%0h expected none", w_op);
            end else begin
              chk("op_fields", 32'(w_op), 32'(exp_q.pop_front()));
            end
            if (n_iss == 0) chk("op0_latency", 32'(age), 32'd1);
            else            chk("gap_len", 32'(low_run), 32'd1);
            if (n_iss < 4) log_op[n_iss] = w_op;
            n_iss++;
            hi_run = 0;
            cur_op = w_op;
          end else begin
            chk("op_stable", 32'(w_op), 32'(cur_op));
          end
          hi_run++;
        end else begin
          if (prev_ov) begin
            idx = n_iss - 1;
            chk("op_high_len", 32'(hi_run), (idx == m_stall) ? 32'(TO + 1) : 32'(m_lat));
            if (test_id == 6 && idx == 1) chk("t6_stuck_len", 32'(hi_run), 32'd101);
            low_run = 0;
          end
          low_run++;
        end
        if (iic_rst) begin
          chk("iic_rst_opv", 32'(op_valid), 32'd0);
          ir_run++;
        end else if (prev_ir) begin
          chk("iic_rst_len", 32'(ir_run), 32'd4);
          ir_run = 0;
        end
        if (rsp_valid) begin
          chk("rsp_one_cycle", 32'(prev_rv), 32'd0);
          chk("rsp_in_txn", 32'(in_txn), 32'd1);
          chk("rsp_fields", 32'({rsp_rdata, rsp_nack, rsp_timeout}), 32'({exp_rd, exp_nack, exp_to}));
          if (exp_to) chk("rsp_after_iic_rst", 32'(prev_ir), 32'd1);
          else        chk("all_ops_issued", 32'(exp_q.size()), 32'd0);
          case (test_id)
            1: begin
              chk("t1_op0", 32'(log_op[0]), 32'h490);
              chk("t1_op1", 32'(log_op[1]), 32'h010);
              chk("t1_op2", 32'(log_op[2]), 32'h2A5);
              chk("t1_nack", 32'(rsp_nack), 32'd0);
            end
            2: begin
              chk("t2_op0", 32'(log_op[0]), 32'h490);
              chk("t2_op1", 32'(log_op[1]), 32'h002);
              chk("t2_op2", 32'(log_op[2]), 32'h491);
              chk("t2_op3", 32'(log_op[3]), 32'h300);
              chk("t2_rdata", 32'(rsp_rdata), 32'h3C);
            end
            3: begin
              chk("t3_nack", 32'(rsp_nack), 32'd1);
              chk("t3_nops", 32'(n_iss), 32'd3);
            end
            4: begin
              chk("t4_nack", 32'(rsp_nack), 32'd0);
              chk("t4_rdata", 32'(rsp_rdata), 32'h5A);
            end
            6: begin
              chk("t6_timeout", 32'(rsp_timeout), 32'd1);
              chk("t6_nops", 32'(n_iss), 32'd2);
            end
            7: begin
              chk("t7_timeout", 32'(rsp_timeout), 32'd0);
              chk("t7_nops", 32'(n_iss), 32'd3);
            end
            default: ;
          endcase
          last_rsp = {exp_rd, exp_nack, exp_to};
          exp_q.delete();
          in_txn = 0;
          rsp_cnt++;
        end else begin
          chk("rsp_hold", 32'({rsp_rdata, rsp_nack, rsp_timeout}), 32'(last_rsp));
        end
        // A command seen with ready high here is taken on the coming edge
        if (cmd_valid && cmd_ready) begin
          exp_q.delete();
          if (cmd_rnw) begin
            exp_q.push_back({3'b100, cmd_addr, 1'b0});
            exp_q.push_back({3'b000, cmd_reg});
            exp_q.push_back({3'b100, cmd_addr, 1'b1});
            exp_q.push_back({3'b011, 8'h00});
            nops = 4;
          end else begin
            exp_q.push_back({3'b100, cmd_addr, 1'b0});
            exp_q.push_back({3'b000, cmd_reg});
            exp_q.push_back({3'b010, cmd_wdata});
            nops = 3;
          end
          m_lat = eng_lat; m_stall = eng_stall;
          exp_to   = (m_stall >= 0) && (m_stall < nops);
          exp_nack = 1'b0;
          for (int i = 0; i < nops; i++) begin
            if (exp_to && i >= m_stall) break;
            if (!(cmd_rnw && i == 3) && eng_err[i]) exp_nack = 1'b1;
          end
          exp_rd = (cmd_rnw && !exp_to) ? eng_rdata : 8'h00;
          in_txn = 1; age = 0; n_iss = 0; wd_fired = 0;
        end
        prev_ov = op_valid; prev_ir = iic_rst; prev_rv = rsp_valid;
      end
    end
  end

  task automatic run_cmd(input int tid, input logic rnw, input logic [6:0] a,
                         input logic [7:0] r, input logic [7:0] w);
    int r0;
    test_id = tid;
    cmd_rnw = rnw; cmd_addr = a; cmd_reg = r; cmd_wdata = w;
    r0 = rsp_cnt;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2000 && rsp_cnt == r0; i++) @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_reg = '0; cmd_wdata = '0;
    eng_lat = 50; eng_stall = -1; eng_err = 4'b0000; eng_rdata = 8'h3C; spur_req = 0; test_id = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_cmd(1, 1'b0, 7'h48, 8'h10, 8'hA5);
    run_cmd(2, 1'b1, 7'h48, 8'h02, 8'h00);
    eng_lat = 3; eng_err = 4'b0001;
    run_cmd(3, 1'b0, 7'h48, 8'h10, 8'hA5);
    eng_lat = 1; eng_err = 4'b1000; eng_rdata = 8'h5A;
    run_cmd(4, 1'b1, 7'h48, 8'h02, 8'h00);
    // stray ack while idle must not start anything
    test_id = 5; eng_err = 4'b0000;
    spur_req++;
    repeat (6) @(posedge clk);
    #1;
    eng_lat = 5; eng_stall = 1;
    run_cmd(6, 1'b0, 7'h48, 8'h10, 8'hA5);
    // ack on the very cycle the timeout would fire
    eng_stall = -1; eng_lat = TO + 1;
    run_cmd(7, 1'b0, 7'h48, 8'h10, 8'hA5);
    // cmd_valid held high with fields changing every cycle
    test_id = 8; eng_lat = 2; eng_err = 4'b0100;
    r0 = rsp_cnt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && rsp_cnt < r0 + 3; i++) begin
      cmd_rnw = 1'($urandom); cmd_addr = 7'($urandom);
      cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset pulse in the middle of a read
    test_id = 9; eng_err = 4'b0000; eng_lat = 50;
    cmd_rnw = 1'b1; cmd_addr = 7'h48; cmd_reg = 8'h02; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (70) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    eng_lat = 4;
    run_cmd(10, 1'b1, 7'h21, 8'h7F, 8'h00);
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miic_reg_seq.md
MIIC_REG_SEQ -- requirements
Module: miic_reg_seq

Interface
REQ-001 Parameter TIMEOUT, default 2000000, SHALL set the maximum number of clk cycles allowed from op_valid rise to op_ack for one byte operation.
REQ-002 Parameter RST_CYCLES, default 4, SHALL set the number of cycles iic_rst is held high after a timeout.
REQ-003 One clock; reset is asynchronous and active-low: clk  in  1  core clock, rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  host command request; cmd_ready  out  1  high when a command can be accepted.
REQ-006 cmd_rnw  in  1  1=register read, 0=register write; cmd_addr  in  7  slave address; cmd_reg  in  8  register index; cmd_wdata  in  8  write data.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  8  read byte; rsp_nack  out  1  slave NACK seen; rsp_timeout  out  1  transaction aborted.
REQ-008 busy  out  1  high from command acceptance until the rsp_valid cycle inclusive.
REQ-009 op_valid, op_start, op_stop, op_rnw  out  1 each; op_wr_data  out  8  byte-op request to the IIC byte engine.
REQ-010 op_rd_data  in  8; op_ack  in  1 (one-cycle pulse); op_err  in  1 (NACK flag, valid on op_ack of a write op).
REQ-011 iic_rst  out  1  active-high synchronous reset request to the byte engine.

Function
REQ-012 Command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_* SHALL be registered at acceptance and ignored afterwards.
REQ-013 cmd_ready SHALL be high only in state IDLE with iic_rst low.
REQ-014 States SHALL be IDLE, ISSUE, WAIT, GAP, RESET, DONE.
REQ-015 Write sequence SHALL be 3 ops: {start=1,stop=0,rnw=0,data={addr,0}}, {0,0,0,reg}, {0,1,0,wdata}.
REQ-016 Read sequence SHALL be 4 ops: {1,0,0,{addr,0}}, {0,0,0,reg}, {1,0,0,{addr,1}} (repeated start), {0,1,1,8'h00}.
REQ-017 IDLE -> ISSUE on acceptance; op_valid SHALL rise the cycle after acceptance with op_* fields of op 0.
REQ-018 ISSUE/WAIT: op_valid and op_* fields SHALL be held stable until the cycle op_ack is sampled high.
REQ-019 On op_ack: op_valid SHALL be low the next cycle (GAP, exactly one cycle), then rise with the next op's fields; after the last op's ack -> DONE.
REQ-020 On op_ack of an op with op_rnw=0, op_err SHALL be OR-ed into a sticky nack flag; op_err SHALL be ignored on read ops.
REQ-021 A NACK SHALL NOT abort the sequence; all ops SHALL be issued so the bus is always terminated by a stop.
REQ-022 On op_ack of the read op, op_rd_data SHALL be captured into rsp_rdata.
REQ-023 DONE SHALL last one cycle: rsp_valid=1, rsp_nack=sticky flag, rsp_timeout=0; then IDLE.
REQ-024 rsp_rdata, rsp_nack, rsp_timeout SHALL hold until the next rsp_valid; for writes rsp_rdata SHALL be 8'h00.
REQ-025 Timeout counter SHALL clear when op_valid rises and count each WAIT cycle; reaching TIMEOUT without op_ack -> RESET.
REQ-026 RESET: op_valid=0, iic_rst=1 for RST_CYCLES cycles, then rsp_valid pulse with rsp_timeout=1, rsp_nack=sticky flag, then IDLE.
REQ-027 op_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (treated as normal ack).
REQ-028 op_ack received in IDLE, GAP, RESET or DONE SHALL be ignored.
REQ-029 Sticky nack flag and timeout counter SHALL clear on command acceptance.

Reset
REQ-030 While rst_n=0 and on release: state IDLE, cmd_ready=1, busy=0, op_valid/op_start/op_stop/op_rnw=0, op_wr_data=0, rsp_valid/rsp_nack/rsp_timeout=0, rsp_rdata=0, iic_rst=0, counters 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it immediately with no rsp_valid; the byte engine is reset externally.

Verification
REQ-032 Write addr=7'h48 reg=8'h10 data=8'hA5, engine acks each op after 50 cycles, op_err=0 -> ops 8'h90(S), 8'h10, 8'hA5(P); one GAP cycle between ops; rsp_valid, rsp_nack=0.
REQ-033 Read addr=7'h48 reg=8'h02, engine returns 8'h3C -> ops 8'h90(S), 8'h02, 8'h91(S), read(P,rnw=1); rsp_rdata=8'h3C, rsp_nack=0.
REQ-034 Write with op_err=1 on address op only -> all 3 ops still issued, rsp_nack=1; op_err=1 on read op alone -> rsp_nack=0.
REQ-035 TIMEOUT=100, engine never acks op 1 -> op_valid drops after 100 WAIT cycles, iic_rst high 4 cycles, rsp_valid with rsp_timeout=1; next command accepted normally.
REQ-036 cmd_valid held high continuously -> back-to-back commands accepted only in IDLE, cmd_* changes during a transaction ignored; rst_n pulsed low mid-read -> all outputs at reset values, no rsp_valid.
